// File: rtl/hex_msg_sequencer_pkg.sv
// Shared character codes, FSM state encoding and square-to-code mapping for
// the six-digit chess status display and its seven-segment drivers.
package hex_msg_sequencer_pkg;

  localparam logic [4:0] CODE_1   = 5'd0;
  localparam logic [4:0] CODE_2   = 5'd1;
  localparam logic [4:0] CODE_3   = 5'd2;
  localparam logic [4:0] CODE_4   = 5'd3;
  localparam logic [4:0] CODE_5   = 5'd4;
  localparam logic [4:0] CODE_6   = 5'd5;
  localparam logic [4:0] CODE_7   = 5'd6;
  localparam logic [4:0] CODE_8   = 5'd7;
  localparam logic [4:0] CODE_A   = 5'd8;
  localparam logic [4:0] CODE_B   = 5'd9;
  localparam logic [4:0] CODE_C   = 5'd10;
  localparam logic [4:0] CODE_D   = 5'd11;
  localparam logic [4:0] CODE_E   = 5'd12;
  localparam logic [4:0] CODE_F   = 5'd13;
  localparam logic [4:0] CODE_G   = 5'd14;
  localparam logic [4:0] CODE_H   = 5'd15;
  localparam logic [4:0] CODE_I   = 5'd16;
  localparam logic [4:0] CODE_L   = 5'd17;
  localparam logic [4:0] CODE_P   = 5'd18;
  localparam logic [4:0] CODE_OFF = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MOVE    = 2'd1,
    ST_ILLEGAL = 2'd2
  } state_t;

  function automatic logic [4:0] rank_code(input logic [2:0] rank);
    return {2'b00, rank};
  endfunction

  function automatic logic [4:0] file_code(input logic [2:0] file);
    return CODE_A + {2'b00, file};
  endfunction

endpackage

// File: rtl/hex_blink_gen.sv
// Free-running blink generator: phase flips every BLINK_HALF cycles; output
// high means blinking digits are currently blanked.
module hex_blink_gen
  import hex_msg_sequencer_pkg::*;
#(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic blank
);

  localparam int CNT_W = $clog2(BLINK_HALF);

  logic [CNT_W-1:0] cnt_reg;
  logic             phase_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (cnt_reg == CNT_W'(BLINK_HALF - 1)) begin
      cnt_reg   <= '0;
      phase_reg <= ~phase_reg;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign blank = phase_reg;

endmodule

// File: rtl/hex_msg_sequencer.sv
// Six-digit status/message sequencer for the chess board display.
// Define HEXMSG_BLINK_EN to enable cursor/banner blinking; otherwise all steady.
module hex_msg_sequencer
  import hex_msg_sequencer_pkg::*;
#(
  parameter int BLINK_HALF  = 25_000_000,
  parameter int HOLD_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       turn,
  input  logic [2:0] cur_file,
  input  logic [2:0] cur_rank,
  input  logic       sel_valid,
  input  logic [2:0] sel_file,
  input  logic [2:0] sel_rank,
  input  logic       move_strobe,
  input  logic [2:0] from_file,
  input  logic [2:0] from_rank,
  input  logic [2:0] to_file,
  input  logic [2:0] to_rank,
  input  logic       illegal_strobe,
  output logic [4:0] dig5,
  output logic [4:0] dig4,
  output logic [4:0] dig3,
  output logic [4:0] dig2,
  output logic [4:0] dig1,
  output logic [4:0] dig0
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES);

  state_t            state_reg, state_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [11:0]       move_reg, move_next;
  logic [5:0][4:0]   dig_reg, dig_next;
  logic              blank;

`ifdef HEXMSG_BLINK_EN
  hex_blink_gen #(
    .BLINK_HALF(BLINK_HALF)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .blank (blank)
  );
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    move_next  = move_reg;
    if (illegal_strobe) begin
      state_next = ST_ILLEGAL;
      hold_next  = '0;
    end else if (move_strobe) begin
      state_next = ST_MOVE;
      hold_next  = '0;
      move_next  = {from_file, from_rank, to_file, to_rank};
    end else if (state_reg != ST_IDLE) begin
      if (hold_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
        state_next = ST_IDLE;
        hold_next  = '0;
      end else begin
        hold_next = hold_reg + 1'b1;
      end
    end
  end

  // Digits are built from the upcoming state so a strobe shows on the next cycle.
  always_comb begin
    dig_next = {6{CODE_OFF}};
    case (state_next)
      ST_MOVE: begin
        dig_next[5] = file_code(move_next[11:9]);
        dig_next[4] = rank_code(move_next[8:6]);
        dig_next[2] = file_code(move_next[5:3]);
        dig_next[1] = rank_code(move_next[2:0]);
      end
      ST_ILLEGAL: begin
        if (!blank) begin
          dig_next[5] = CODE_I;
          dig_next[4] = CODE_L;
          dig_next[3] = CODE_L;
        end
      end
      default: begin
        dig_next[5] = CODE_P;
        dig_next[4] = turn ? CODE_2 : CODE_1;
        if (!blank) begin
          dig_next[3] = file_code(cur_file);
          dig_next[2] = rank_code(cur_rank);
        end
        if (sel_valid) begin
          dig_next[1] = file_code(sel_file);
          dig_next[0] = rank_code(sel_rank);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
      move_reg  <= '0;
      dig_reg   <= {6{CODE_OFF}};
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      move_reg  <= move_next;
      dig_reg   <= dig_next;
    end
  end

  assign dig5 = dig_reg[5];
  assign dig4 = dig_reg[4];
  assign dig3 = dig_reg[3];
  assign dig2 = dig_reg[2];
  assign dig1 = dig_reg[1];
  assign dig0 = dig_reg[0];

endmodule

// File: tb/tb_hex_msg_sequencer.sv
// Self-checking bench for hex_msg_sequencer against a cycle-level behavioural model.
// Blink expectations follow whether HEXMSG_BLINK_EN is defined for the build.
module tb_hex_msg_sequencer;

  localparam int BH   = 4;
  localparam int HOLD = 10;
`ifdef HEXMSG_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       turn = 1'b0;
  logic [2:0] cur_file = 3'd4, cur_rank = 3'd3;
  logic       sel_valid = 1'b0;
  logic [2:0] sel_file = 3'd0, sel_rank = 3'd0;
  logic       move_strobe = 1'b0, illegal_strobe = 1'b0;
  logic [2:0] from_file = 3'd0, from_rank = 3'd0, to_file = 3'd0, to_rank = 3'd0;
  logic [4:0] dig5, dig4, dig3, dig2, dig1, dig0;

  int checks = 0;
  int fails  = 0;

  // model state
  int          remain = 0;      // cycles of message display still owed
  int          kind = 0;        // 1 = move, 2 = illegal
  int          since_rel = 0;   // edges since reset release
  int          mf, mr, mtf, mtr;
  logic [29:0] exp_w;

  always #5 clk = ~clk;

  hex_msg_sequencer #(.BLINK_HALF(BH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .turn(turn), .cur_file(cur_file), .cur_rank(cur_rank),
    .sel_valid(sel_valid), .sel_file(sel_file), .sel_rank(sel_rank),
    .move_strobe(move_strobe), .from_file(from_file), .from_rank(from_rank),
    .to_file(to_file), .to_rank(to_rank), .illegal_strobe(illegal_strobe),
    .dig5(dig5), .dig4(dig4), .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0)
  );

  function automatic logic [29:0] pack(int a, int b, int c, int d, int e, int f);
    return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(f)};
  endfunction

  function automatic logic [29:0] got_w();
    return {dig5, dig4, dig3, dig2, dig1, dig0};
  endfunction

  // What the display must show after the edge just taken, given the inputs held over it.
  task automatic model_edge();
    bit blank;
    if (reset) begin
      exp_w = pack(31, 31, 31, 31, 31, 31);
      remain = 0;
      since_rel = 0;
      return;
    end
    if (illegal_strobe) begin
      kind = 2; remain = HOLD;
    end else if (move_strobe) begin
      kind = 1; remain = HOLD;
      mf = from_file; mr = from_rank; mtf = to_file; mtr = to_rank;
    end else if (remain > 0) begin
      remain--;
    end
    blank = BLINK_EN && (((since_rel / BH) % 2) == 1);
    if (remain > 0 && kind == 1)
      exp_w = pack(8 + mf, mr, 31, 8 + mtf, mtr, 31);
    else if (remain > 0)
      exp_w = blank ? pack(31, 31, 31, 31, 31, 31) : pack(16, 17, 17, 31, 31, 31);
    else
      exp_w = pack(18, turn ? 1 : 0, blank ? 31 : 8 + cur_file, blank ? 31 : cur_rank,
                   sel_valid ? 8 + sel_file : 31, sel_valid ? sel_rank : 31);
    since_rel++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; turn = 0; cur_file = 3'd4; cur_rank = 3'd3; sel_valid = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (got_w() !== pack(31, 31, 31, 31, 31, 31)) begin
        fails++;
        $display("FAIL reset cyc%0d got=%h want=%h", i, got_w(), pack(31, 31, 31, 31, 31, 31));
      end
    end
  endtask

  task automatic test_idle_blink();
    reset = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      checks++;
      if (got_w() !== exp_w) begin
        fails++;
        $display("FAIL idle_blink cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
    end
  endtask

  task automatic test_move();
    from_file = 3'd4; from_rank = 3'd1; to_file = 3'd4; to_rank = 3'd3;
    move_strobe = 1;
    tick();
    move_strobe = 0;
    checks++;
    if (got_w() !== pack(12, 1, 31, 12, 3, 31)) begin
      fails++;
      $display("FAIL move_first got=%h want=%h", got_w(), pack(12, 1, 31, 12, 3, 31));
    end
    from_file = 3'd0; to_rank = 3'd7;   // ignored without strobe
    for (int i = 1; i <= HOLD + 2; i++) begin
      tick();
      checks++;
      if (got_w() !== exp_w) begin
        fails++;
        $display("FAIL move_hold cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
    end
  endtask

  task automatic test_simultaneous();
    from_file = 3'd0; from_rank = 3'd0; to_file = 3'd7; to_rank = 3'd7;
    move_strobe = 1; illegal_strobe = 1;
    tick();
    move_strobe = 0; illegal_strobe = 0;
    for (int i = 0; i < HOLD + 3; i++) begin
      checks++;
      if (got_w() !== exp_w || dig5 === 5'd8) begin
        fails++;
        $display("FAIL simultaneous cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
      tick();
    end
  endtask

  task automatic test_retrigger();
    from_file = 3'd1; from_rank = 3'd0; to_file = 3'd2; to_rank = 3'd2;
    move_strobe = 1;
    tick();
    move_strobe = 0;
    repeat (4) tick();
    from_file = 3'd6; from_rank = 3'd7; to_file = 3'd5; to_rank = 3'd5;
    move_strobe = 1;
    tick();
    move_strobe = 0;
    for (int i = 1; i <= HOLD + 2; i++) begin
      checks++;
      if (got_w() !== exp_w) begin
        fails++;
        $display("FAIL retrigger cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_illegal();
    illegal_strobe = 1;
    tick();
    illegal_strobe = 0;
    repeat (3) tick();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (got_w() !== pack(31, 31, 31, 31, 31, 31)) begin
        fails++;
        $display("FAIL reset_mid cyc%0d got=%h want=%h", i, got_w(), pack(31, 31, 31, 31, 31, 31));
      end
    end
    reset = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (got_w() !== exp_w) begin
        fails++;
        $display("FAIL after_reset cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
    end
  endtask

  task automatic test_sel_turn();
    turn = 1; sel_valid = 1; sel_file = 3'd7; sel_rank = 3'd7;
    for (int i = 0; i < 2 * BH + 2; i++) begin
      tick();
      checks++;
      if (got_w() !== exp_w || dig1 !== 5'd15 || dig0 !== 5'd7) begin
        fails++;
        $display("FAIL sel_turn cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      turn = 1'($urandom); sel_valid = 1'($urandom);
      cur_file = 3'($urandom); cur_rank = 3'($urandom);
      sel_file = 3'($urandom); sel_rank = 3'($urandom);
      from_file = 3'($urandom); from_rank = 3'($urandom);
      to_file = 3'($urandom); to_rank = 3'($urandom);
      move_strobe = ($urandom_range(0, 15) == 0);
      illegal_strobe = ($urandom_range(0, 23) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
      checks++;
      if (got_w() !== exp_w) begin
        fails++;
        $display("FAIL random cyc%0d got=%h want=%h", i, got_w(), exp_w);
      end
    end
    reset = 0; move_strobe = 0; illegal_strobe = 0;
  endtask

  initial begin
    test_reset();
    test_idle_blink();
    test_move();
    test_simultaneous();
    test_retrigger();
    test_reset_mid_illegal();
    test_sel_turn();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
